// File: rtl/mem_stage_wb_pkg.sv
// Shared pipeline definitions for the memory stage: FSM states, widths,
// alignment mask and the MEM/WB payload.
package mem_stage_wb_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [1:0] ALIGN_MASK = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_register;
        logic [WORD_W-1:0]     write_data;
    } wb_t;

endpackage

// File: rtl/mem_stage_wb_if.sv
// Data-memory bus with a req/ack handshake.
//   master: MemReq, MemWe, MemAddr, MemWData out; MemRData, MemAck in
//   slave : the reverse
interface mem_stage_wb_if;
    import mem_stage_wb_pkg::*;

    logic              MemReq;
    logic              MemWe;
    logic [WORD_W-1:0] MemAddr;
    logic [WORD_W-1:0] MemWData;
    logic [WORD_W-1:0] MemRData;
    logic              MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData,
        output MemRData, MemAck
    );
endinterface

// File: rtl/mem_stage_wb_wbreg.sv
// MEM/WB pipeline register.
//   clk, rst  : clock, async active-high reset (clears all fields)
//   bubble_i  : load a bubble (reg_write = 0, other fields hold)
//   wb_d_i    : next write-back triple
//   wb_q_o    : registered write-back triple
module mem_wb_reg
    import mem_stage_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bubble_i,
    input  wb_t  wb_d_i,
    output wb_t  wb_q_o
);

    wb_t wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else if (bubble_i) begin
            wb_q.reg_write <= 1'b0;
        end else begin
            wb_q <= wb_d_i;
        end
    end

    assign wb_q_o = wb_q;

endmodule

// File: rtl/mem_stage_wb.sv
// Memory stage plus MEM/WB register for the 5-stage MIPS core.
//   clk, rst        : clock, async active-high reset
//   EX/MEM inputs   : ALUResult, ReadDataRF1, WriteRegister, RegWrite,
//                     MemRead, MemWrite, MemToReg
//   bus             : data-memory req/ack bus (master side)
//   Stall           : freeze the front of the pipeline this cycle
//   MemErr          : sticky misaligned/timeout flag
//   WB*             : registered write-back triple
module mem_stage_wb
    import mem_stage_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     ALUResult,
    input  logic [WORD_W-1:0]     ReadDataRF1,
    input  logic [REG_ADDR_W-1:0] WriteRegister,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemToReg,
    mem_stage_wb_if.master        bus,
    output logic                  Stall,
    output logic                  MemErr,
    output logic                  WBRegWrite,
    output logic [REG_ADDR_W-1:0] WBWriteRegister,
    output logic [WORD_W-1:0]     WBWriteData
);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic access, misaligned;
    logic req, stall, complete, timed_out;
    wb_t  wb_d, wb_q;

    assign access     = MemRead | MemWrite;
    assign misaligned = access & (ALUResult[1:0] != ALIGN_MASK);

    // State, wait counter and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state, handshake and completion control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req       = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    err_d = 1'b1;
                end else if (access) begin
                    req = 1'b1;
                    if (bus.MemAck) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                // An ack on the timeout cycle wins over the timeout
                if (bus.MemAck) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-back payload: memory data only on a completing access
    always_comb begin
        wb_d.reg_write      = RegWrite & ~misaligned;
        wb_d.write_register = WriteRegister;
        if (complete && MemToReg) begin
            wb_d.write_data = timed_out ? '0 : bus.MemRData;
        end else begin
            wb_d.write_data = ALUResult;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (stall),
        .wb_d_i   (wb_d),
        .wb_q_o   (wb_q)
    );

    // Request and stall drop the moment reset asserts, even mid-WAIT
    assign bus.MemReq   = req & ~rst;
    assign bus.MemWe    = MemWrite;
    assign bus.MemAddr  = ALUResult;
    assign bus.MemWData = ReadDataRF1;
    assign Stall        = stall & ~rst;

    assign MemErr          = err_q;
    assign WBRegWrite      = wb_q.reg_write;
    assign WBWriteRegister = wb_q.write_register;
    assign WBWriteData     = wb_q.write_data;

endmodule

// File: tb/tb_mem_stage_wb.sv
module tb_mem_stage_wb;
    import mem_stage_wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WORD_W-1:0]     ALUResult;
    logic [WORD_W-1:0]     ReadDataRF1;
    logic [REG_ADDR_W-1:0] WriteRegister;
    logic                  RegWrite;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  MemToReg;
    logic                  Stall;
    logic                  MemErr;
    logic                  WBRegWrite;
    logic [REG_ADDR_W-1:0] WBWriteRegister;
    logic [WORD_W-1:0]     WBWriteData;

    int tests  = 0;
    int failed = 0;

    mem_stage_wb_if bus ();

    mem_stage_wb #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ALUResult       (ALUResult),
        .ReadDataRF1     (ReadDataRF1),
        .WriteRegister   (WriteRegister),
        .RegWrite        (RegWrite),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .MemToReg        (MemToReg),
        .bus             (bus),
        .Stall           (Stall),
        .MemErr          (MemErr),
        .WBRegWrite      (WBRegWrite),
        .WBWriteRegister (WBWriteRegister),
        .WBWriteData     (WBWriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ALUResult     = '0;
        ReadDataRF1   = '0;
        WriteRegister = '0;
        RegWrite      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemToReg      = 1'b0;
        bus.MemAck    = 1'b0;
        bus.MemRData  = '0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst_memreq", 32'(bus.MemReq), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        chk("rst_wbrw", 32'(WBRegWrite), 32'd0);
        chk("rst_wbdata", WBWriteData, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type pass-through
        RegWrite = 1'b1; WriteRegister = 5'd5; ALUResult = 32'h1234;
        #1;
        chk("rtype_stall", 32'(Stall), 32'd0);
        chk("rtype_req", 32'(bus.MemReq), 32'd0);
        edge_step();
        chk("rtype_wbrw", 32'(WBRegWrite), 32'd1);
        chk("rtype_wbreg", 32'(WBWriteRegister), 32'd5);
        chk("rtype_wbdata", WBWriteData, 32'h1234);

        // Zero-wait load
        ALUResult = 32'h40; MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
        WriteRegister = 5'd7; bus.MemAck = 1'b1; bus.MemRData = 32'hDEADBEEF;
        #1;
        chk("zw_req", 32'(bus.MemReq), 32'd1);
        chk("zw_addr", bus.MemAddr, 32'h40);
        chk("zw_stall", 32'(Stall), 32'd0);
        edge_step();
        chk("zw_wbdata", WBWriteData, 32'hDEADBEEF);
        chk("zw_wbreg", 32'(WBWriteRegister), 32'd7);
        chk("zw_wbrw", 32'(WBRegWrite), 32'd1);

        // 3-wait store, ack in the 4th cycle
        idle_inputs();
        ALUResult = 32'h80; ReadDataRF1 = 32'hA5A5A5A5; MemWrite = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.MemAck = (c == 3);
            #1;
            chk($sformatf("st_req_c%0d", c), 32'(bus.MemReq), 32'd1);
            chk($sformatf("st_we_c%0d", c), 32'(bus.MemWe), 32'd1);
            chk($sformatf("st_wdata_c%0d", c), bus.MemWData, 32'hA5A5A5A5);
            chk($sformatf("st_stall_c%0d", c), 32'(Stall), (c < 3) ? 32'd1 : 32'd0);
            edge_step();
            chk($sformatf("st_wbrw_c%0d", c), 32'(WBRegWrite), 32'd0);
            chk($sformatf("st_err_c%0d", c), 32'(MemErr), 32'd0);
        end

        // Misaligned load
        idle_inputs();
        ALUResult = 32'h42; MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
        WriteRegister = 5'd4;
        #1;
        chk("mis_req", 32'(bus.MemReq), 32'd0);
        chk("mis_stall", 32'(Stall), 32'd0);
        edge_step();
        chk("mis_err", 32'(MemErr), 32'd1);
        chk("mis_wbrw", 32'(WBRegWrite), 32'd0);
        idle_inputs();
        edge_step();
        chk("mis_err_sticky", 32'(MemErr), 32'd1);

        // Clear the error, then ack exactly on the timeout cycle
        rst = 1'b1;
        #2;
        chk("rst2_err", 32'(MemErr), 32'd0);
        rst = 1'b0;
        ALUResult = 32'h100; MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
        WriteRegister = 5'd8; bus.MemRData = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            bus.MemAck = (c == 4);
            #1;
            chk($sformatf("toack_stall_c%0d", c), 32'(Stall), (c < 4) ? 32'd1 : 32'd0);
            edge_step();
        end
        chk("toack_wbdata", WBWriteData, 32'hCAFEF00D);
        chk("toack_wbrw", 32'(WBRegWrite), 32'd1);
        chk("toack_err", 32'(MemErr), 32'd0);

        // Timeout with no ack: data forced to zero, error raised
        idle_inputs();
        ALUResult = 32'h104; MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
        WriteRegister = 5'd9; bus.MemRData = 32'h11111111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("to_stall_c%0d", c), 32'(Stall), (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("to_req_c%0d", c), 32'(bus.MemReq), 32'd1);
            edge_step();
            if (c < 4) chk($sformatf("to_wbrw_c%0d", c), 32'(WBRegWrite), 32'd0);
        end
        chk("to_wbrw", 32'(WBRegWrite), 32'd1);
        chk("to_wbreg", 32'(WBWriteRegister), 32'd9);
        chk("to_wbdata", WBWriteData, 32'd0);
        chk("to_err", 32'(MemErr), 32'd1);
        idle_inputs();
        RegWrite = 1'b1; WriteRegister = 5'd2; ALUResult = 32'h55;
        #1;
        chk("to_idle_stall", 32'(Stall), 32'd0);
        chk("to_idle_req", 32'(bus.MemReq), 32'd0);
        edge_step();
        chk("to_idle_wbdata", WBWriteData, 32'h55);

        // Reset mid-WAIT
        idle_inputs();
        ALUResult = 32'h200; MemRead = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
        WriteRegister = 5'd6;
        edge_step();
        edge_step();
        chk("mid_stall_pre", 32'(Stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req", 32'(bus.MemReq), 32'd0);
        chk("mid_stall", 32'(Stall), 32'd0);
        chk("mid_wbreg", 32'(WBWriteRegister), 32'd0);
        chk("mid_wbdata", WBWriteData, 32'd0);
        chk("mid_err", 32'(MemErr), 32'd0);
        rst = 1'b0;
        ALUResult = 32'h204; WriteRegister = 5'd3;
        bus.MemAck = 1'b1; bus.MemRData = 32'h600D;
        #1;
        chk("post_req", 32'(bus.MemReq), 32'd1);
        chk("post_stall", 32'(Stall), 32'd0);
        edge_step();
        chk("post_wbdata", WBWriteData, 32'h600D);
        chk("post_wbreg", 32'(WBWriteRegister), 32'd3);
        chk("post_wbrw", 32'(WBRegWrite), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
